result_write_arbiter: RTL

Round-robin arbiter that shares the single pixel write port (oX/oY/oR/oG/oB) among the NUM_PARALLEL box_filter result lanes of the adaptive-threshold datapath. It replaces fixed-priority result muxing, guarantees no result is lost when several lanes finish a pixel in the same cycle, and counts written pixels so the controller knows when the whole frame has landed. It sits between the box_filter instances and the top-level pixel outputs.

---
 rtl/result_write_arbiter_pkg.sv | 23 ++
 rtl/result_write_arbiter_if.sv | 22 ++
 rtl/result_write_arbiter_rr_priority_picker.sv | 32 +++
 rtl/result_write_arbiter.sv | 85 ++++++++
 4 files changed

// File: rtl/result_write_arbiter_pkg.sv
// Shared sizing for the adaptive-threshold result path: lane count, coordinate
// widths and frame size, plus the wrap-around lane arithmetic used by arbiters.
package result_write_arbiter_pkg;

  localparam int unsigned NUM_PARALLEL      = 7;
  localparam int unsigned NUM_PARALLEL_BITS = 3;
  localparam int unsigned WIDTH_BITS        = 8;
  localparam int unsigned HEIGHT_BITS       = 8;
  localparam int unsigned COUNT_BITS        = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam int unsigned FRAME_PIXELS      = 32'(1) << (WIDTH_BITS + HEIGHT_BITS);

  // (base + offset) mod NUM_PARALLEL, valid for base, offset < NUM_PARALLEL
  function automatic logic [NUM_PARALLEL_BITS-1:0] lane_add(
    input logic [NUM_PARALLEL_BITS-1:0] base,
    input int unsigned                  offset
  );
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= NUM_PARALLEL) sum = sum - NUM_PARALLEL;
    return NUM_PARALLEL_BITS'(sum);
  endfunction

endpackage

// File: rtl/result_write_arbiter_if.sv
// Result request bundle between the box_filter lanes (master) and the
// write arbiter (slave).
interface result_write_arbiter_if;
  import result_write_arbiter_pkg::*;

  logic [NUM_PARALLEL-1:0]             iReqValid;
  logic [NUM_PARALLEL*WIDTH_BITS-1:0]  iReqCol;
  logic [NUM_PARALLEL*HEIGHT_BITS-1:0] iReqRow;
  logic [NUM_PARALLEL-1:0]             iReqData;
  logic [NUM_PARALLEL-1:0]             oReqReady;

  modport master (
    output iReqValid, iReqCol, iReqRow, iReqData,
    input  oReqReady
  );

  modport slave (
    input  iReqValid, iReqCol, iReqRow, iReqData,
    output oReqReady
  );

endinterface

// File: rtl/result_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid lane at or after ptr, wrapping.
// Shared with the input_rom_reader port sharing.
module result_write_arbiter_rr_priority_picker
  import result_write_arbiter_pkg::*;
(
  input  logic [NUM_PARALLEL-1:0]      valid,
  input  logic [NUM_PARALLEL_BITS-1:0] ptr,
  output logic [NUM_PARALLEL-1:0]      grant_c,
  output logic [NUM_PARALLEL_BITS-1:0] winner_c,
  output logic                         any_c
);

  logic                         found;
  logic [NUM_PARALLEL_BITS-1:0] idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    winner_c = '0;
    grant_c  = '0;
    for (int unsigned k = 0; k < NUM_PARALLEL; k++) begin
      idx = lane_add(ptr, k);
      if (!found && valid[idx]) begin
        found    = 1'b1;
        winner_c = idx;
      end
    end
    if (found) grant_c = NUM_PARALLEL'(1) << winner_c;
    any_c = found;
  end

endmodule

// File: rtl/result_write_arbiter.sv
// Round-robin arbiter sharing the single pixel write port among the box_filter
// result lanes; registers the written pixel and counts pixels per frame.
module result_write_arbiter
  import result_write_arbiter_pkg::*;
(
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   iClear,
  result_write_arbiter_if.slave  req,
  output logic [HEIGHT_BITS-1:0] oX,
  output logic [WIDTH_BITS-1:0]  oY,
  output logic [2:0]             oR,
  output logic [2:0]             oG,
  output logic [2:0]             oB,
  output logic                   oWren,
  output logic [COUNT_BITS-1:0]  oWriteCount,
  output logic                   oAllWritten
);

  localparam logic [COUNT_BITS-1:0] FRAME_COUNT = COUNT_BITS'(FRAME_PIXELS);

  logic [NUM_PARALLEL_BITS-1:0] ptr;
  logic [NUM_PARALLEL_BITS-1:0] ptr_nxt_c;
  logic [NUM_PARALLEL_BITS-1:0] winner_c;
  logic [NUM_PARALLEL-1:0]      grant_c;
  logic                         any_c;
  logic                         transfer_c;
  logic [COUNT_BITS-1:0]        count_nxt_c;
  logic [WIDTH_BITS-1:0]        sel_col_c;
  logic [HEIGHT_BITS-1:0]       sel_row_c;
  logic                         sel_data_c;

  result_write_arbiter_rr_priority_picker u_picker (
    .valid    (req.iReqValid),
    .ptr      (ptr),
    .grant_c  (grant_c),
    .winner_c (winner_c),
    .any_c    (any_c)
  );

  // Clear suppresses the grant so no lane believes its result was taken
  assign req.oReqReady = iClear ? '0 : grant_c;
  assign transfer_c    = any_c & ~iClear;
  assign ptr_nxt_c     = lane_add(winner_c, 1);

  assign sel_col_c  = req.iReqCol[winner_c * WIDTH_BITS +: WIDTH_BITS];
  assign sel_row_c  = req.iReqRow[winner_c * HEIGHT_BITS +: HEIGHT_BITS];
  assign sel_data_c = req.iReqData[winner_c];

  // Count saturates at one full frame
  assign count_nxt_c = (oWriteCount == FRAME_COUNT) ? oWriteCount
                                                    : oWriteCount + COUNT_BITS'(1);

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      ptr         <= '0;
      oX          <= '0;
      oY          <= '0;
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
      oWren       <= 1'b0;
      oWriteCount <= '0;
      oAllWritten <= 1'b0;
    end else if (iClear) begin
      ptr         <= '0;
      oWren       <= 1'b0;
      oWriteCount <= '0;
      oAllWritten <= 1'b0;
    end else if (transfer_c) begin
      ptr         <= ptr_nxt_c;
      oX          <= sel_row_c;
      oY          <= sel_col_c;
      oR          <= {3{sel_data_c}};
      oG          <= {3{sel_data_c}};
      oB          <= {3{sel_data_c}};
      oWren       <= 1'b1;
      oWriteCount <= count_nxt_c;
      oAllWritten <= (count_nxt_c == FRAME_COUNT);
    end else begin
      oWren       <= 1'b0;
    end
  end

endmodule
